// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the memory arbiter slice.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

    localparam int unsigned N_REQ_DEF = 3;

    // Index width for n items; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned OWNER_W = idx_w(N_REQ_DEF);

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and MMU-side bus of the memory arbiter.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_W = 32,
    parameter int unsigned N_REQ = N_REQ_DEF
);
    localparam int unsigned BE_W = MEM_W / 8;

    logic [N_REQ-1:0]             rq_req_i;
    logic [N_REQ-1:0]             rq_gnt_o;
    logic [N_REQ-1:0][31:0]       rq_addr_i;
    logic [N_REQ-1:0]             rq_we_i;
    logic [N_REQ-1:0][BE_W-1:0]   rq_be_i;
    logic [N_REQ-1:0][MEM_W-1:0]  rq_wdata_i;
    logic [N_REQ-1:0]             rq_rvalid_o;
    logic [N_REQ-1:0]             rq_err_o;
    logic [MEM_W-1:0]             rq_rdata_o;

    logic                         mem_req_o;
    logic                         mem_we_o;
    logic [31:0]                  mem_addr_o;
    logic [BE_W-1:0]              mem_be_o;
    logic [MEM_W-1:0]             mem_wdata_o;
    logic                         mem_rvalid_i;
    logic                         mem_err_i;
    logic [MEM_W-1:0]             mem_rdata_i;

    logic                         busy_o;

    modport slave (
        input  rq_req_i, rq_addr_i, rq_we_i, rq_be_i, rq_wdata_i,
        output rq_gnt_o, rq_rvalid_o, rq_err_o, rq_rdata_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        input  mem_rvalid_i, mem_err_i, mem_rdata_i,
        output busy_o
    );

    modport master (
        output rq_req_i, rq_addr_i, rq_we_i, rq_be_i, rq_wdata_i,
        input  rq_gnt_o, rq_rvalid_o, rq_err_o, rq_rdata_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        output mem_rvalid_i, mem_err_i, mem_rdata_i,
        input  busy_o
    );

endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin select: first asserted request at or above ptr, wrapping.
module rr_picker
    import mem_arb_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned IDX_W = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid_c,
    output logic [IDX_W-1:0] idx_c
);

    int unsigned cand;

    always_comb begin
        valid_c = 1'b0;
        idx_c   = '0;
        cand    = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = (32'(ptr) + k) % N_REQ;
            if (!valid_c && req[IDX_W'(cand)]) begin
                valid_c = 1'b1;
                idx_c   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter funnelling N requesters into one outstanding MMU transaction.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_W   = 32,
    parameter int unsigned N_REQ   = N_REQ_DEF,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst,
    mem_arbiter_if.slave   bus
);

    localparam int unsigned IDX_W = idx_w(N_REQ);
    localparam int unsigned BE_W  = MEM_W / 8;
    localparam int unsigned CNT_W = idx_w(TIMEOUT + 1);

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  owner_q;
    logic [31:0]       addr_q;
    logic              we_q;
    logic [BE_W-1:0]   be_q;
    logic [MEM_W-1:0]  wdata_q;

    logic              pick_valid_c;
    logic [IDX_W-1:0]  pick_idx_c;
    logic              latch_c;
    logic [N_REQ-1:0]  gnt_c, rvalid_c, err_c;
    logic [MEM_W-1:0]  rdata_c;
    logic              mem_req_c, mem_we_c;
    logic [31:0]       mem_addr_c;
    logic [BE_W-1:0]   mem_be_c;
    logic [MEM_W-1:0]  mem_wdata_c;

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_picker (
        .req     (bus.rq_req_i),
        .ptr     (ptr_q),
        .valid_c (pick_valid_c),
        .idx_c   (pick_idx_c)
    );

    // State, pointer, wait counter and the granted request's fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            owner_q <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            if (latch_c) begin
                owner_q <= pick_idx_c;
                addr_q  <= bus.rq_addr_i[pick_idx_c];
                we_q    <= bus.rq_we_i[pick_idx_c];
                be_q    <= bus.rq_be_i[pick_idx_c];
                wdata_q <= bus.rq_wdata_i[pick_idx_c];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        latch_c     = 1'b0;
        gnt_c       = '0;
        rvalid_c    = '0;
        err_c       = '0;
        rdata_c     = '0;
        mem_req_c   = 1'b0;
        mem_we_c    = 1'b0;
        mem_addr_c  = '0;
        mem_be_c    = '0;
        mem_wdata_c = '0;

        unique case (state_q)
            ST_IDLE: begin
                // Grant is combinational so the requester sees it in its request cycle.
                if (pick_valid_c && !rst) begin
                    gnt_c[pick_idx_c] = 1'b1;
                    latch_c           = 1'b1;
                    ptr_d             = (pick_idx_c == IDX_W'(N_REQ - 1)) ? '0
                                                                          : pick_idx_c + IDX_W'(1);
                    state_d           = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_req_c   = 1'b1;
                mem_we_c    = we_q;
                mem_addr_c  = addr_q;
                mem_be_c    = be_q;
                mem_wdata_c = wdata_q;
                cnt_d       = '0;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                // Error beats rvalid; any response beats the timeout.
                if (bus.mem_err_i) begin
                    err_c[owner_q] = 1'b1;
                    state_d        = ST_IDLE;
                end else if (bus.mem_rvalid_i) begin
                    rvalid_c[owner_q] = 1'b1;
                    rdata_c           = bus.mem_rdata_i;
                    state_d           = ST_IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    err_c[owner_q] = 1'b1;
                    state_d        = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.rq_gnt_o    = gnt_c;
    assign bus.rq_rvalid_o = rvalid_c;
    assign bus.rq_err_o    = err_c;
    assign bus.rq_rdata_o  = rdata_c;
    assign bus.mem_req_o   = mem_req_c;
    assign bus.mem_we_o    = mem_we_c;
    assign bus.mem_addr_o  = mem_addr_c;
    assign bus.mem_be_o    = mem_be_c;
    assign bus.mem_wdata_o = mem_wdata_c;
    assign bus.busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized transactions.
module tb_mem_arbiter;

    localparam int unsigned MEM_W = 32;
    localparam int unsigned N     = 3;
    localparam int unsigned TMO   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.MEM_W(MEM_W), .N_REQ(N)) bus ();

    mem_arbiter #(
        .MEM_W   (MEM_W),
        .N_REQ   (N),
        .TIMEOUT (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int mptr     = 0;

    logic [31:0] f_addr  [N];
    logic        f_we    [N];
    logic [3:0]  f_be    [N];
    logic [31:0] f_wdata [N];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mem_vec();
        return 128'({bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_be_o, bus.mem_wdata_o});
    endfunction

    function automatic logic [2:0] onehot(input int w);
        return (w < 0) ? 3'b000 : 3'(1 << w);
    endfunction

    task automatic chk_resp(input string tag, input logic [2:0] rv, input logic [2:0] er,
                            input logic [31:0] rd);
        chk({tag, ".rvalid"}, 128'(bus.rq_rvalid_o), 128'(rv));
        chk({tag, ".err"},    128'(bus.rq_err_o),    128'(er));
        chk({tag, ".rdata"},  128'(bus.rq_rdata_o),  128'(rd));
    endtask

    task automatic rand_fields();
        for (int i = 0; i < N; i++) begin
            f_addr[i]  = $urandom;
            f_we[i]    = 1'($urandom);
            f_be[i]    = 4'($urandom);
            f_wdata[i] = $urandom;
        end
    endtask

    task automatic drive(input logic [2:0] v);
        bus.rq_req_i = v;
        for (int i = 0; i < N; i++) begin
            bus.rq_addr_i[i]  = f_addr[i];
            bus.rq_we_i[i]    = f_we[i];
            bus.rq_be_i[i]    = f_be[i];
            bus.rq_wdata_i[i] = f_wdata[i];
        end
    endtask

    // Reference winner: first set bit scanning upward from the pointer, modulo N.
    function automatic int pick(input logic [2:0] v, input int p);
        int w = -1;
        for (int k = 0; k < N; k++)
            if (w < 0 && v[(p + k) % N]) w = (p + k) % N;
        return w;
    endfunction

    // One full transaction. d = WAIT cycle index of the MMU response; kind 0 ok, 1 err, 2 both.
    task automatic txn(input logic [2:0] v, input int d, input int kind, input bit stray,
                       input logic [31:0] rdv);
        int w;
        logic [127:0] exp_mem;
        logic resp, tmo;
        logic [31:0] rd;
        @(posedge clk); #1;
        drive(v);
        bus.mem_rvalid_i = stray;
        bus.mem_err_i    = 1'b0;
        bus.mem_rdata_i  = $urandom;
        w = pick(v, mptr);
        @(negedge clk);
        chk("idle.gnt",  128'(bus.rq_gnt_o), 128'(onehot(w)));
        chk("idle.busy", 128'(bus.busy_o), 128'(0));
        chk("idle.mem",  mem_vec(), 128'(0));
        chk_resp("idle", 3'b000, 3'b000, 32'h0);
        exp_mem = 128'({1'b1, f_we[w], f_addr[w], f_be[w], f_wdata[w]});
        mptr = (w + 1) % N;

        @(posedge clk); #1;
        rand_fields();
        drive(3'($urandom));
        bus.mem_rvalid_i = stray;
        bus.mem_err_i    = stray & 1'($urandom);
        @(negedge clk);
        chk("issue.mem",  mem_vec(), exp_mem);
        chk("issue.gnt",  128'(bus.rq_gnt_o), 128'(0));
        chk("issue.busy", 128'(bus.busy_o), 128'(1));
        chk_resp("issue", 3'b000, 3'b000, 32'h0);

        for (int j = 0; j <= int'(TMO); j++) begin
            @(posedge clk); #1;
            drive(3'($urandom));
            resp = (j == d);
            tmo  = !resp && (j == int'(TMO));
            rd   = resp ? rdv : $urandom;
            bus.mem_rvalid_i = resp && (kind != 1);
            bus.mem_err_i    = resp && (kind != 0);
            bus.mem_rdata_i  = rd;
            @(negedge clk);
            chk("wait.gnt",  128'(bus.rq_gnt_o), 128'(0));
            chk("wait.busy", 128'(bus.busy_o), 128'(1));
            chk("wait.mem",  mem_vec(), 128'(0));
            chk_resp("wait",
                     (resp && kind == 0) ? onehot(w) : 3'b000,
                     ((resp && kind != 0) || tmo) ? onehot(w) : 3'b000,
                     (resp && kind == 0) ? rd : 32'h0);
            if (resp || tmo) break;
        end
    endtask

    task automatic idle_cycle(input bit stray);
        @(posedge clk); #1;
        drive(3'b000);
        bus.mem_rvalid_i = stray;
        bus.mem_err_i    = stray & 1'($urandom);
        bus.mem_rdata_i  = $urandom;
        @(negedge clk);
        chk("gap.gnt",  128'(bus.rq_gnt_o), 128'(0));
        chk("gap.busy", 128'(bus.busy_o), 128'(0));
        chk("gap.mem",  mem_vec(), 128'(0));
        chk_resp("gap", 3'b000, 3'b000, 32'h0);
    endtask

    initial begin
        rand_fields();
        drive(3'b111);
        bus.mem_rvalid_i = 1'b0;
        bus.mem_err_i    = 1'b0;
        bus.mem_rdata_i  = 32'h0;

        // Reset holds everything quiet even with requests pending.
        repeat (2) @(negedge clk);
        chk("rst.busy", 128'(bus.busy_o), 128'(0));
        chk("rst.gnt",  128'(bus.rq_gnt_o), 128'(0));
        chk("rst.mem",  mem_vec(), 128'(0));
        chk_resp("rst", 3'b000, 3'b000, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(3'b000);
        mptr = 0;

        // Contention: all requesters always asking -> 0,1,2,0.
        for (int i = 0; i < 4; i++) begin
            rand_fields();
            txn(3'b111, $urandom_range(0, 3), 0, 1'b0, $urandom);
        end
        chk("rr.ptr_wrapped", 128'(mptr), 128'(1));

        // Single read: addr 0x1004, response two cycles after mem_req.
        rand_fields();
        f_addr[1] = 32'h0000_1004;
        f_we[1]   = 1'b0;
        txn(3'b010, 1, 0, 1'b0, 32'hDEAD_BEEF);

        // Error and rvalid together: error wins, busy drops next cycle.
        rand_fields();
        txn(3'b100, 0, 2, 1'b0, $urandom);
        idle_cycle(1'b0);

        // Silent MMU: timeout on the fifth WAIT cycle, then a stray rvalid in IDLE.
        rand_fields();
        txn(3'($urandom_range(1, 7)), 9, 0, 1'b0, $urandom);
        idle_cycle(1'b1);

        // Randomized traffic with strays, errors and timeouts mixed in.
        for (int i = 0; i < 40; i++) begin
            rand_fields();
            txn(3'($urandom_range(1, 7)), $urandom_range(0, 6), $urandom_range(0, 2),
                1'($urandom), $urandom);
            if ($urandom_range(0, 3) == 0) idle_cycle(1'($urandom));
        end

        // Reset during WAIT abandons the transaction and rewinds the pointer.
        rand_fields();
        txn(3'b001, 0, 0, 1'b0, $urandom);
        @(posedge clk); #1;
        rand_fields();
        drive(3'b111);
        bus.mem_rvalid_i = 1'b0;
        bus.mem_err_i    = 1'b0;
        @(negedge clk);
        chk("rstw.gnt", 128'(bus.rq_gnt_o), 128'(onehot(pick(3'b111, mptr))));
        @(posedge clk); #1;
        drive(3'b000);
        @(negedge clk);
        chk("rstw.issue", 128'(bus.mem_req_o), 128'(1));
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstw.wait_busy", 128'(bus.busy_o), 128'(1));
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rstw.busy_async", 128'(bus.busy_o), 128'(0));
        mptr = 0;
        @(posedge clk); #1;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = $urandom;
        @(negedge clk);
        chk("rstw.in_rst_busy", 128'(bus.busy_o), 128'(0));
        chk_resp("rstw.in_rst", 3'b000, 3'b000, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstw.post_busy", 128'(bus.busy_o), 128'(0));
        chk("rstw.post_gnt",  128'(bus.rq_gnt_o), 128'(0));
        chk_resp("rstw.post", 3'b000, 3'b000, 32'h0);
        @(posedge clk); #1;
        bus.mem_rvalid_i = 1'b0;
        drive(3'b111);
        @(negedge clk);
        chk("rstw.next_gnt", 128'(bus.rq_gnt_o), 128'(onehot(pick(3'b111, mptr))));
        chk("rstw.next_is_0", 128'(bus.rq_gnt_o), 128'(3'b001));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
